ahb_burst_master: RTL and testbench
===================================

Name: ahb_burst_master

Overview:
- Single-channel AHB initiator. Converts a simple request/response client interface into AHB single and incrementing-burst transfers on one master port of the bus matrix.
- It is the requesting end of the protocol answered by the slaves and the default slave. It honours wait states and the two-cycle ERROR response, and cancels the rest of a burst after an error.
- No arbitration signals; the port is always granted.

Parameters:
- MAX_LEN_BITS, 4, width of req_len; one request carries at most 2^MAX_LEN_BITS beats.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  client request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  32  start byte address
- req_size  in  3  HSIZE encoding, 0..2 legal
- req_len  in  MAX_LEN_BITS  beats minus 1
- wdata  in  32  current write beat (first-word-fall-through source)
- wdata_pop  out  1  current wdata consumed; source advances
- rsp_valid  out  1  one beat completed
- rsp_rdata  out  32  read data, valid with rsp_valid on reads
- rsp_err  out  1  beat ended in ERROR
- rsp_last  out  1  final response of the request
- HTRANS  out  `AHB_TRANS_BITS (2)  IDLE=00, NONSEQ=10, SEQ=11; BUSY is never driven
- HADDR  out  32
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  SINGLE=000 when req_len==0, otherwise INCR=001
- HWDATA  out  32
- HREADY  in  1
- HRESP  in  `AHB_RESP_BITS (2)  OKAY=00, ERROR=01
- HRDATA  in  32

Behaviour:
- Reset values (async, HRESETn low):
  - HTRANS=IDLE; HADDR, HWRITE, HSIZE, HBURST, HWDATA all 0.
  - rsp_valid, rsp_err, rsp_last, wdata_pop all 0.
  - FSM in IDLE.
  - req_ready=1 after reset.
- Reset mid-burst aborts immediately and emits no response.
- All AHB outputs are registered.
- FSM states:
  - IDLE: req_ready=1. On handshake, latch the request; next cycle drive NONSEQ with the first address; go ADDR.
  - ADDR: an address phase is outstanding with no prior data phase.
  - PIPE: an address phase overlaps the previous beat's data phase.
  - LAST: data phase of the final beat only; HTRANS=IDLE.
  - ERR2: second error cycle.
- Address and control rules:
  - Low address bits are forced to zero per size (size 1 clears bit 0; size 2 clears bits 1:0).
  - Address and control are held stable while HREADY=0.
  - An address phase is accepted on a rising edge with HREADY=1. On acceptance, the next beat's address is HADDR + (1<<HSIZE) with HTRANS=SEQ.
- 1 KB boundary: if the next address has bits [9:0]==0, that beat is driven NONSEQ instead of SEQ. HBURST stays INCR.
- Beat counting:
  - Issue counter counts accepted address phases.
  - Completion counter counts data phases ending with HREADY=1.
  - After the last address is accepted, HTRANS=IDLE.
- Writes:
  - At address-phase acceptance, HWDATA is loaded from wdata on the same edge, and wdata_pop pulses for that cycle.
  - HWDATA is then held through wait states.
- Responses:
  - On each data phase ending with HREADY=1 and HRESP=OKAY: rsp_valid=1 for one cycle and rsp_err=0.
  - rsp_rdata=HRDATA on reads; 0 on writes.
  - rsp_last=1 on the final beat.
- Error handling:
  - First error cycle (HREADY=0, HRESP=ERROR): on the next edge HTRANS becomes IDLE and the FSM goes to ERR2. Any pending address phase is cancelled and never re-issued.
  - ERR2 (HREADY=1, HRESP=ERROR): rsp_valid=1, rsp_err=1, rsp_last=1. Then return to IDLE.
  - Remaining beats produce no responses and no wdata_pop.
- Completion: after rsp_last, the FSM returns to IDLE, and req_ready rises the cycle after rsp_last. There is therefore at least one HTRANS=IDLE cycle between requests.
- A wait state with HRESP=OKAY simply stalls. Counters do not move.

Test Plan:
- Single read: addr 0x0000_0100, size 2, len 0, no wait.
  - Expect NONSEQ/0x100/HBURST=000 for 1 cycle, then IDLE.
  - Next cycle rsp_valid=1, rsp_rdata=HRDATA, rsp_last=1.
- Write INCR4 at 0x200, size 2, 2-cycle HREADY=0 on beat 1.
  - Expect HADDR 0x200,0x204,0x208,0x20C with NONSEQ,SEQ,SEQ,SEQ.
  - 0x208 held through the stall; HWDATA held; exactly 4 wdata_pop and 4 rsp_valid; rsp_last on the 4th.
- 1 KB crossing: addr 0x3F8, size 2, len 3 read.
  - Expect HTRANS NONSEQ,SEQ,NONSEQ,SEQ at 0x3F8,0x3FC,0x400,0x404.
- Error on beat 0 of a len-3 read to an unmapped address (default slave returns ERROR, ERROR).
  - HTRANS=IDLE in the second error cycle; single rsp with rsp_err=1, rsp_last=1.
  - No further NONSEQ/SEQ; req_ready=1 the next cycle.
- Halfword burst: addr 0x101, size 1, len 2.
  - Expect HADDR 0x100,0x102,0x104, HSIZE=001.
- HRESETn low during beat 2 of an INCR8.
  - Outputs return to reset values asynchronously; no rsp_valid.
  - After release, a new request issues cleanly.

Source files
------------

// File: rtl/ahb_burst_master_if.sv
// Client request/response and AHB master-port signals for ahb_burst_master.
interface ahb_burst_master_if #(parameter int MAX_LEN_BITS = 4);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [2:0]              req_size;
  logic [MAX_LEN_BITS-1:0] req_len;
  logic [31:0]             wdata;
  logic                    wdata_pop;
  logic                    rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_last;
  logic [1:0]              HTRANS;
  logic [31:0]             HADDR;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [31:0]             HWDATA;
  logic                    HREADY;
  logic [1:0]              HRESP;
  logic [31:0]             HRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_len, wdata,
    output req_ready, wdata_pop, rsp_valid, rsp_rdata, rsp_err, rsp_last,
    output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_len, wdata,
    input  req_ready, wdata_pop, rsp_valid, rsp_rdata, rsp_err, rsp_last,
    input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_burst_master.sv
// Single-channel AHB initiator: turns client requests into SINGLE/INCR bursts,
// honours wait states and the two-cycle ERROR response.
module ahb_burst_master #(
  parameter int MAX_LEN_BITS = 4
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_burst_master_if.master bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR2} state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic [1:0]              r_htrans;
  logic [31:0]             r_haddr;
  logic                    r_hwrite;
  logic [2:0]              r_hsize;
  logic [2:0]              r_hburst;
  logic [31:0]             r_hwdata;
  logic [MAX_LEN_BITS-1:0] r_len;
  logic [MAX_LEN_BITS-1:0] r_iss;
  logic [MAX_LEN_BITS-1:0] r_cmp;
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_rsp_last;

  logic [31:0] w_next_addr;
  logic        w_accept;
  logic        w_err1;
  logic        w_last_iss;
  logic        w_last_cmp;

  function automatic logic [31:0] f_align(input logic [31:0] a, input logic [2:0] sz);
    case (sz)
      3'd1:    return {a[31:1], 1'b0};
      3'd2:    return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

  assign w_next_addr = r_haddr + (32'd1 << r_hsize);
  assign w_accept    = r_htrans[1] & bus.HREADY;
  assign w_err1      = !bus.HREADY && (bus.HRESP == RESP_ERR);
  assign w_last_iss  = (r_iss == r_len);
  assign w_last_cmp  = (r_cmp == r_len);

  // Pop is combinational so the FWFT source advances on the edge HWDATA samples it.
  assign bus.wdata_pop = w_accept & r_hwrite;
  assign bus.req_ready = r_ready;
  assign bus.HTRANS    = r_htrans;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = r_hsize;
  assign bus.HBURST    = r_hburst;
  assign bus.HWDATA    = r_hwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_last  = r_rsp_last;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_htrans    <= TR_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hburst    <= '0;
      r_hwdata    <= '0;
      r_len       <= '0;
      r_iss       <= '0;
      r_cmp       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
      if (w_accept && r_hwrite) r_hwdata <= bus.wdata;

      case (r_state)
        S_IDLE: begin
          // r_ready stays low for the rsp_last cycle, then rises here.
          if (r_ready && bus.req_valid) begin
            r_ready  <= 1'b0;
            r_htrans <= TR_NONSEQ;
            r_haddr  <= f_align(bus.req_addr, bus.req_size);
            r_hwrite <= bus.req_write;
            r_hsize  <= bus.req_size;
            r_hburst <= (bus.req_len == '0) ? 3'b000 : 3'b001;
            r_len    <= bus.req_len;
            r_iss    <= '0;
            r_cmp    <= '0;
            r_state  <= S_ADDR;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_ADDR, S_PIPE: begin
          if (r_state == S_PIPE && w_err1) begin
            r_htrans <= TR_IDLE;
            r_state  <= S_ERR2;
          end else if (bus.HREADY) begin
            if (r_state == S_PIPE) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= r_hwrite ? 32'd0 : bus.HRDATA;
              r_rsp_last  <= w_last_cmp;
              r_cmp       <= r_cmp + MAX_LEN_BITS'(1);
            end
            if (w_last_iss) begin
              r_htrans <= TR_IDLE;
              r_state  <= S_LAST;
            end else begin
              // Crossing a 1 KB boundary restarts the burst with NONSEQ.
              r_haddr  <= w_next_addr;
              r_htrans <= (w_next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
              r_iss    <= r_iss + MAX_LEN_BITS'(1);
              r_state  <= S_PIPE;
            end
          end
        end

        S_LAST: begin
          if (w_err1) begin
            r_state <= S_ERR2;
          end else if (bus.HREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_hwrite ? 32'd0 : bus.HRDATA;
            r_rsp_last  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        S_ERR2: begin
          if (bus.HREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: table of bursts plus error and reset sequences.
module tb_ahb_burst_master;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [31:0] wptr = 32'd0;
  int n_tests = 0;
  int n_fail  = 0;

  ahb_burst_master_if #(.MAX_LEN_BITS(4)) bus ();

  ahb_burst_master #(.MAX_LEN_BITS(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  // FWFT write source
  assign bus.wdata = 32'hC0DE_0000 + wptr;
  always @(posedge HCLK) if (bus.wdata_pop) wptr <= wptr + 32'd1;

  typedef struct {
    logic              wr;
    logic [31:0]       addr;
    logic [2:0]        size;
    logic [3:0]        len;
    int                stall_beat;
    int                stall_n;
    int                nbeats;
    logic [2:0]        burst;
    logic [3:0][31:0]  ea;
    logic [3:0][1:0]   et;
  } vec_t;

  vec_t vt[5];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [3:0] len, input int sb, input int sn, input int nb,
                              input logic [2:0] burst,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [1:0] t0, input logic [1:0] t1,
                              input logic [1:0] t2, input logic [1:0] t3);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.len = len;
    v.stall_beat = sb; v.stall_n = sn; v.nbeats = nb; v.burst = burst;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.et[0] = t0; v.et[1] = t1; v.et[2] = t2; v.et[3] = t3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w = 0;
    @(negedge HCLK);
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge HCLK);
      w++;
    end
    if (w >= 20) chk({nm, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Plays slave for one request and checks every cycle against the vector.
  task automatic run_req(input vec_t v, input string nm);
    int nph = 0, npop = 0, nrsp = 0, bad = 0, cyc = 0, stall = 0, dbeat = -1, nd;
    logic done = 1'b0, pend = 1'b0, pend_last = 1'b0, held = 1'b0;
    logic [31:0] pend_rd = 0, exp_hw = 0, held_addr = 0, da = 0, nda;
    logic [3:0][31:0] ga;
    logic [3:0][1:0]  gt;
    ga = '0; gt = '0;
    wait_ready(nm);
    bus.req_valid = 1'b1; bus.req_write = v.wr; bus.req_addr = v.addr;
    bus.req_size = v.size; bus.req_len = v.len;
    @(posedge HCLK); #1;
    bus.req_valid = 1'b0;
    while (!done && cyc < 200) begin
      bus.HREADY = 1'b1; bus.HRESP = 2'b00;
      if (dbeat >= 0 && dbeat == v.stall_beat && stall < v.stall_n) begin
        bus.HREADY = 1'b0; stall++;
      end
      bus.HRDATA = 32'hA500_0000 ^ da;
      @(negedge HCLK);
      if (bus.rsp_valid !== pend) bad++;
      if (pend && (bus.rsp_rdata !== pend_rd || bus.rsp_last !== pend_last || bus.rsp_err !== 1'b0)) bad++;
      if (bus.rsp_valid) nrsp++;
      pend = 1'b0;
      if (held && bus.HADDR !== held_addr) bad++;
      held = 1'b0;
      if (bus.wdata_pop) npop++;
      nd = -1; nda = da;
      if (dbeat >= 0) begin
        if (v.wr && bus.HWDATA !== exp_hw) bad++;
        if (bus.HREADY) begin
          pend = 1'b1; pend_rd = v.wr ? 32'd0 : bus.HRDATA; pend_last = (dbeat == int'(v.len));
        end else nd = dbeat;
      end
      if (bus.HTRANS[1]) begin
        if (!bus.HREADY) begin
          held = 1'b1; held_addr = bus.HADDR;
        end else begin
          if (nph < 4) begin ga[nph] = bus.HADDR; gt[nph] = bus.HTRANS; end
          if (bus.HSIZE !== v.size || bus.HWRITE !== v.wr || bus.HBURST !== v.burst) bad++;
          if (v.wr) begin exp_hw = bus.wdata; if (bus.wdata_pop !== 1'b1) bad++; end
          nd = nph; nda = bus.HADDR; nph++;
        end
      end
      dbeat = nd; da = nda;
      if (bus.rsp_valid && bus.rsp_last) begin
        done = 1'b1;
        if (bus.req_ready !== 1'b0) bad++;
      end else begin
        @(posedge HCLK); #1;
      end
      cyc++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_nphase"}, nph, v.nbeats);
    for (int i = 0; i < v.nbeats && i < 4; i++) begin
      chk($sformatf("%s_haddr%0d", nm, i), ga[i], v.ea[i]);
      chk($sformatf("%s_htrans%0d", nm, i), 32'(gt[i]), 32'(v.et[i]));
    end
    chk({nm, "_npop"}, npop, v.wr ? v.nbeats : 0);
    chk({nm, "_nrsp"}, nrsp, v.nbeats);
    chk({nm, "_cycle_errs"}, bad, 0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk({nm, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    chk({nm, "_rsp_after"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_idle_after"}, 32'(bus.HTRANS), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, guard, cnt;
    vt[0] = mk(1'b0, 32'h100, 3'd2, 4'd0, -1, 0, 1, 3'b000,
               32'h100, 32'h0, 32'h0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00);
    vt[1] = mk(1'b1, 32'h200, 3'd2, 4'd3, 1, 2, 4, 3'b001,
               32'h200, 32'h204, 32'h208, 32'h20C, 2'b10, 2'b11, 2'b11, 2'b11);
    vt[2] = mk(1'b0, 32'h3F8, 3'd2, 4'd3, -1, 0, 4, 3'b001,
               32'h3F8, 32'h3FC, 32'h400, 32'h404, 2'b10, 2'b11, 2'b10, 2'b11);
    vt[3] = mk(1'b0, 32'h101, 3'd1, 4'd2, -1, 0, 3, 3'b001,
               32'h100, 32'h102, 32'h104, 32'h0, 2'b10, 2'b11, 2'b11, 2'b00);
    vt[4] = mk(1'b1, 32'h123, 3'd0, 4'd1, 0, 1, 2, 3'b001,
               32'h123, 32'h124, 32'h0, 32'h0, 2'b10, 2'b11, 2'b00, 2'b00);

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_size = '0; bus.req_len = '0;
    bus.HREADY = 1'b1; bus.HRESP = 2'b00; bus.HRDATA = '0;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
    chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
    chk("rst_hburst", 32'(bus.HBURST), 32'd0);
    chk("rst_hwdata", bus.HWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_wdata_pop", 32'(bus.wdata_pop), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    HRESETn = 1'b1;

    for (int i = 0; i < 5; i++) run_req(vt[i], $sformatf("vec%0d", i));

    // Error on beat 0 of a len-3 read
    wait_ready("err");
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0F00_0000;
    bus.req_size = 3'd2; bus.req_len = 4'd3;
    @(posedge HCLK); #1;
    bus.req_valid = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
    @(negedge HCLK);
    chk("err_nonseq", 32'(bus.HTRANS), 32'h2);
    chk("err_addr", bus.HADDR, 32'h0F00_0000);
    @(posedge HCLK); #1;
    bus.HREADY = 1'b0; bus.HRESP = 2'b01;
    @(negedge HCLK);
    chk("err1_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge HCLK); #1;
    bus.HREADY = 1'b1; bus.HRESP = 2'b01;
    @(negedge HCLK);
    chk("err2_idle", 32'(bus.HTRANS), 32'd0);
    chk("err2_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge HCLK); #1;
    bus.HRESP = 2'b00;
    @(negedge HCLK);
    chk("err_rsp_fields", {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_last}, 32'd7);
    chk("err_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("err_ready_high", 32'(bus.req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) cnt++;
      @(negedge HCLK);
    end
    chk("err_quiet_after", cnt, 0);

    // Reset during beat 2 of an INCR8 write
    wait_ready("rst");
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h500;
    bus.req_size = 3'd2; bus.req_len = 4'd7;
    @(posedge HCLK); #1;
    bus.req_valid = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
    acc = 0; guard = 0;
    while (acc < 3 && guard < 50) begin
      @(negedge HCLK);
      if (bus.HTRANS[1] && bus.HREADY) acc++;
      guard++;
      if (acc < 3) begin @(posedge HCLK); #1; end
    end
    chk("rst_setup", acc, 3);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("arst_haddr", bus.HADDR, 32'd0);
    chk("arst_hwdata", bus.HWDATA, 32'd0);
    chk("arst_ctl", {25'd0, bus.HWRITE, bus.HSIZE, bus.HBURST}, 32'd0);
    chk("arst_pop_rsp", {30'd0, bus.wdata_pop, bus.rsp_valid}, 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      if (bus.rsp_valid !== 1'b0 || bus.HTRANS !== 2'b00) cnt++;
    end
    chk("arst_quiet", cnt, 0);
    HRESETn = 1'b1;
    run_req(vt[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
